// File: rtl/sha256_core_arbiter_if.sv
// Client and core bundle for the shared SHA-256 block core arbiter.
// slave = arbiter side, master = clients plus core side.
interface sha256_core_arbiter_if #(
  parameter int unsigned N_CLI = 4,
  parameter int unsigned SW    = 256,
  parameter int unsigned DW    = 512,
  parameter int unsigned LW    = 7
);
  logic [N_CLI-1:0]    cli_req;
  logic [N_CLI-1:0]    cli_1st;
  logic [N_CLI-1:0]    cli_seed;
  logic [N_CLI-1:0]    cli_final;
  logic [N_CLI*SW-1:0] cli_state;
  logic [N_CLI*DW-1:0] cli_data;
  logic [N_CLI*LW-1:0] cli_len;
  logic [N_CLI-1:0]    cli_gnt;
  logic [N_CLI-1:0]    cli_done;
  logic [SW-1:0]       cli_dout;

  logic                sha256_start;
  logic                sha256_1st;
  logic                sha256_seed;
  logic                sha256_final;
  logic [SW-1:0]       sha256_state;
  logic [DW-1:0]       sha256_din;
  logic [LW-1:0]       sha256_len;
  logic                sha256_done;
  logic [SW-1:0]       sha256_dout;

  modport slave (
    input  cli_req, cli_1st, cli_seed, cli_final, cli_state, cli_data, cli_len,
    input  sha256_done, sha256_dout,
    output cli_gnt, cli_done, cli_dout,
    output sha256_start, sha256_1st, sha256_seed, sha256_final,
    output sha256_state, sha256_din, sha256_len
  );

  modport master (
    output cli_req, cli_1st, cli_seed, cli_final, cli_state, cli_data, cli_len,
    output sha256_done, sha256_dout,
    input  cli_gnt, cli_done, cli_dout,
    input  sha256_start, sha256_1st, sha256_seed, sha256_final,
    input  sha256_state, sha256_din, sha256_len
  );
endinterface

// File: rtl/sha256_core_arbiter.sv
// N-client arbiter in front of one shared SHA-256 block core: grant, capture
// operands, issue one job, return digest and done to the grantee.
module sha256_core_arbiter #(
  parameter int unsigned N_CLI = 4,
  parameter int unsigned RR_EN = 1,
  parameter int unsigned SW    = 256,
  parameter int unsigned DW    = 512,
  parameter int unsigned LW    = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  sha256_core_arbiter_if.slave  bus,
  output logic                  busy,
  output logic                  err_spurious
);

  localparam int unsigned PW = (N_CLI > 1) ? $clog2(N_CLI) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic          win_vld;

  // Winner: first requester scanning from ptr (RR) or from 0 (fixed priority).
  // Scan runs high-to-low so the lowest scan offset is assigned last and wins.
  always_comb begin : pick_winner
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = int'(N_CLI) - 1; k >= 0; k--) begin
      if (RR_EN != 0) cand = PW'((int'(ptr) + k) % int'(N_CLI));
      else            cand = PW'(k);
      if (bus.cli_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin : fsm
    if (!rstn) begin
      state            <= IDLE;
      ptr              <= '0;
      gidx             <= '0;
      busy             <= 1'b0;
      err_spurious     <= 1'b0;
      bus.cli_gnt      <= '0;
      bus.cli_done     <= '0;
      bus.cli_dout     <= '0;
      bus.sha256_start <= 1'b0;
      bus.sha256_1st   <= 1'b0;
      bus.sha256_seed  <= 1'b0;
      bus.sha256_final <= 1'b0;
      bus.sha256_state <= '0;
      bus.sha256_din   <= '0;
      bus.sha256_len   <= '0;
    end else begin
      bus.sha256_start <= 1'b0;
      bus.cli_done     <= '0;
      // A done outside WAIT has no job to belong to; flag it and ignore it.
      if (bus.sha256_done && (state != WAIT)) err_spurious <= 1'b1;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state            <= ISSUE;
            busy             <= 1'b1;
            gidx             <= win_idx;
            bus.cli_gnt      <= N_CLI'(1) << win_idx;
            bus.sha256_start <= 1'b1;
            bus.sha256_1st   <= bus.cli_1st[win_idx];
            bus.sha256_seed  <= bus.cli_seed[win_idx];
            bus.sha256_final <= bus.cli_final[win_idx];
            bus.sha256_state <= bus.cli_state[int'(win_idx)*int'(SW) +: SW];
            bus.sha256_din   <= bus.cli_data[int'(win_idx)*int'(DW) +: DW];
            bus.sha256_len   <= bus.cli_len[int'(win_idx)*int'(LW) +: LW];
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.sha256_done) begin
            state        <= RESP;
            bus.cli_dout <= bus.sha256_dout;
            bus.cli_done <= N_CLI'(1) << gidx;
          end
        end
        RESP: begin
          state       <= IDLE;
          busy        <= 1'b0;
          bus.cli_gnt <= '0;
          if (RR_EN != 0) ptr <= PW'((int'(gidx) + 1) % int'(N_CLI));
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Random-stimulus bench for sha256_core_arbiter: three configurations
// (4 RR, 4 fixed priority, 5 RR) checked against a timestamp job model.
module tb_sha256_core_arbiter;

  localparam int unsigned SW = 256;
  localparam int unsigned DW = 512;
  localparam int unsigned LW = 7;

  logic clk;
  logic rstn;
  int unsigned n_vec;
  int unsigned n_err;
  bit          use_force;
  bit          spur_en;
  bit          inject;
  bit          lat_fix;
  logic [7:0]  req_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  for (genvar v = 0; v < 3; v++) begin : g_dut
    localparam int unsigned N  = (v == 2) ? 5 : 4;
    localparam int unsigned RR = (v == 1) ? 0 : 1;

    sha256_core_arbiter_if #(.N_CLI(N), .SW(SW), .DW(DW), .LW(LW)) bus ();
    logic busy;
    logic err_spurious;

    sha256_core_arbiter #(.N_CLI(N), .RR_EN(RR), .SW(SW), .DW(DW), .LW(LW)) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .bus          (bus),
      .busy         (busy),
      .err_spurious (err_spurious)
    );

    // Clients: new random requests and operands every cycle.
    initial begin : drive_cli
      forever begin
        @(negedge clk);
        bus.cli_req   = use_force ? N'(req_force) : N'($urandom & $urandom);
        bus.cli_1st   = N'($urandom);
        bus.cli_seed  = N'($urandom);
        bus.cli_final = N'($urandom);
        for (int w = 0; w < int'(N*SW/32); w++) bus.cli_state[w*32 +: 32] = $urandom;
        for (int w = 0; w < int'(N*DW/32); w++) bus.cli_data[w*32 +: 32] = $urandom;
        for (int i = 0; i < int'(N); i++) bus.cli_len[i*LW +: LW] = LW'($urandom);
      end
    end

    // Core: done L cycles after start, plus optional stray pulses.
    initial begin : core_model
      int cnt;
      cnt = 0;
      bus.sha256_done = 1'b0;
      bus.sha256_dout = '0;
      forever begin
        @(negedge clk);
        bus.sha256_done = 1'b0;
        if (bus.sha256_start === 1'b1) cnt = lat_fix ? 10 : int'($urandom_range(1, 6));
        else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) bus.sha256_done = 1'b1;
        end
        if (inject || (spur_en && $urandom_range(0, 40) == 0)) bus.sha256_done = 1'b1;
        if (bus.sha256_done)
          for (int w = 0; w < int'(SW/32); w++) bus.sha256_dout[w*32 +: 32] = $urandom;
      end
    end

    // Reference: a job granted on sampling cycle tg, core done on cycle td.
    initial begin : scoreboard
      bit act, wait_ok, found;
      int tg, td, arm_at, last, n, g, base, idx;
      logic [N-1:0]  r;
      logic          dn;
      logic [SW-1:0] dd;
      logic [SW-1:0] e_state, e_dout;
      logic [DW-1:0] e_din;
      logic [LW-1:0] e_len;
      logic [2:0]    e_flags;
      logic          e_err;
      string         pfx;
      pfx = $sformatf("cfg%0d", v);
      n = -1;
      act = 1'b0; tg = 0; td = -1; arm_at = 0; last = int'(N) - 1; g = 0;
      e_state = '0; e_dout = '0; e_din = '0; e_len = '0; e_flags = '0; e_err = 1'b0;
      forever begin
        @(posedge clk);
        n++;
        r  = bus.cli_req;
        dn = bus.sha256_done;
        dd = bus.sha256_dout;
        if (rstn !== 1'b1) begin
          act = 1'b0; tg = 0; td = -1; arm_at = 0; last = int'(N) - 1; g = 0;
          e_state = '0; e_dout = '0; e_din = '0; e_len = '0; e_flags = '0; e_err = 1'b0;
        end else begin
          wait_ok = act && (td < 0) && (n >= tg + 2);
          if (dn && !wait_ok) e_err = 1'b1;
          if (dn && wait_ok) begin
            td = n;
            e_dout = dd;
          end
          if (act && td >= 0 && n == td + 1) begin
            act = 1'b0;
            arm_at = n + 1;
            last = g;
          end
          if (!act && n >= arm_at && r != '0) begin
            base = (RR != 0) ? (last + 1) % int'(N) : 0;
            found = 1'b0;
            for (int k = 0; k < int'(N) && !found; k++) begin
              idx = (base + k) % int'(N);
              if (r[idx]) begin
                g = idx;
                found = 1'b1;
              end
            end
            e_flags = {bus.cli_1st[g], bus.cli_seed[g], bus.cli_final[g]};
            e_state = bus.cli_state[g*SW +: SW];
            e_din   = bus.cli_data[g*DW +: DW];
            e_len   = bus.cli_len[g*LW +: LW];
            act = 1'b1;
            tg = n;
            td = -1;
          end
        end
        #1;
        check_eq({pfx, ".gnt"},   bus.cli_gnt,  act ? (N'(1) << g) : N'(0));
        check_eq({pfx, ".start"}, bus.sha256_start, act && n == tg);
        check_eq({pfx, ".done"},  bus.cli_done,
                 (act && td >= 0 && n == td) ? (N'(1) << g) : N'(0));
        check_eq({pfx, ".busy"},  busy, act);
        check_eq({pfx, ".err"},   err_spurious, e_err);
        check_eq({pfx, ".dout"},  bus.cli_dout, e_dout);
        check_eq({pfx, ".state"}, bus.sha256_state, e_state);
        check_eq({pfx, ".din"},   bus.sha256_din, e_din);
        check_eq({pfx, ".len"},   bus.sha256_len, e_len);
        check_eq({pfx, ".flags"},
                 {bus.sha256_1st, bus.sha256_seed, bus.sha256_final}, e_flags);
      end
    end
  end

  initial begin : main
    logic [7:0] pats [4];
    bit seen;
    pats = '{8'hFF, 8'h0A, 8'h11, 8'h18};
    n_vec = 0; n_err = 0;
    use_force = 1'b0; spur_en = 1'b0; inject = 1'b0; lat_fix = 1'b0; req_force = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (1200) @(negedge clk);

    // Held request patterns: full contention, starvation under fixed priority, wrap.
    use_force = 1'b1;
    for (int p = 0; p < 4; p++) begin
      req_force = pats[p];
      repeat (250) @(negedge clk);
    end
    req_force = '0;
    repeat (20) @(negedge clk);

    // Stray core done while every arbiter is idle.
    @(posedge clk); inject = 1'b1;
    @(posedge clk); inject = 1'b0;
    repeat (10) @(negedge clk);

    use_force = 1'b0; spur_en = 1'b1;
    repeat (600) @(negedge clk);
    spur_en = 1'b0; use_force = 1'b1; req_force = '0;
    repeat (30) @(negedge clk);

    // Reset while the core is busy; its late done must be flagged.
    lat_fix = 1'b1; req_force = 8'h01; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (g_dut[0].bus.sha256_start === 1'b1) seen = 1'b1;
    end
    check_eq("rst_job_start", seen, 1);
    req_force = '0;
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    lat_fix = 1'b0; req_force = 8'h01;
    repeat (40) @(negedge clk);
    req_force = '0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
